// File: rtl/stg_scheduler.sv
// Stage descriptor scheduler: prefetches stage ROM words into a ring buffer ahead of the
// scroll position, lap-adjusting positions on each ROM pass and retiring passed blocks.
module stg_scheduler #(
   parameter int unsigned BLK_BITS   = 52,
   parameter int unsigned POS_DIGIT  = 16,
   parameter int unsigned STG_DEPTH  = 8,
   parameter int unsigned BUFFER_LEN = 8,
   parameter int unsigned LAP_LEN    = 4096,
   parameter int unsigned H_RES      = 800,
   localparam int unsigned STG_ADDRW = (STG_DEPTH > 1) ? $clog2(STG_DEPTH) : 1,
   localparam int unsigned BUF_AW    = (BUFFER_LEN > 1) ? $clog2(BUFFER_LEN) : 1
) (
   input  logic                 i_clk_pix,
   input  logic                 i_rst,
   input  logic                 i_start,
   input  logic [POS_DIGIT-1:0] i_map_x,
   output logic                 o_rom_en,
   output logic [STG_ADDRW-1:0] o_rom_addr,
   input  logic [BLK_BITS-1:0]  i_rom_data,
   input  logic [BUF_AW-1:0]    i_rd_idx,
   output logic [BLK_BITS-1:0]  o_rd_blk,
   output logic [BUF_AW:0]      o_count,
   output logic                 o_ready,
   output logic [7:0]           o_lap
);

   localparam int unsigned LEFT_LSB  = BLK_BITS - POS_DIGIT;
   localparam int unsigned RIGHT_LSB = BLK_BITS - 2 * POS_DIGIT;

   typedef enum logic [1:0] {StIdle, StPreload, StRun} state_e;

   state_e                state_q, state_d;
   logic [STG_ADDRW-1:0]  rom_addr_q, rom_addr_d;
   logic [7:0]            lap_q, lap_d;
   logic [7:0]            wr_lap_q, wr_lap_d;
   logic [BUF_AW:0]       count_q, count_d;
   logic [BUF_AW-1:0]     head_q, head_d;
   logic [BUF_AW-1:0]     tail_q, tail_d;
   logic                  pend_q, pend_d;
   logic [BLK_BITS-1:0]   buf_q [BUFFER_LEN];
   logic [BLK_BITS-1:0]   buf_d [BUFFER_LEN];

   logic                  active;
   logic                  fetch_ok;
   logic                  fetch;
   logic                  retire;
   logic                  wr;
   logic [POS_DIGIT-1:0]  map_eff;
   logic [POS_DIGIT:0]    horizon;
   logic [BUF_AW-1:0]     newest_ptr;
   logic [BUF_AW-1:0]     rd_ptr;
   logic [POS_DIGIT-1:0]  newest_left;
   logic [POS_DIGIT-1:0]  oldest_right;
   logic [POS_DIGIT-1:0]  lap_off;
   logic [BLK_BITS-1:0]   wr_blk;

   // ---------------------------------------------------------------- decision logic
   always_comb begin
      active       = (state_q != StIdle);
      map_eff      = (state_q == StPreload) ? '0 : i_map_x;
      horizon      = {1'b0, map_eff} + (POS_DIGIT + 1)'(H_RES);
      newest_ptr   = tail_q - BUF_AW'(1);
      newest_left  = buf_q[newest_ptr][LEFT_LSB +: POS_DIGIT];
      oldest_right = buf_q[head_q][RIGHT_LSB +: POS_DIGIT];
      // pend_q already blocks issue, so the pending slot need not be added to count_q here
      fetch_ok     = !pend_q && (count_q < (BUF_AW + 1)'(BUFFER_LEN)) &&
                     ((count_q == '0) || ({1'b0, newest_left} <= horizon));
      fetch        = active && fetch_ok;
      retire       = active && (count_q != '0) && (oldest_right < i_map_x);
      wr           = pend_q;
   end

   // Lap offset follows the read, not the current lap counter, since the wrap bumps lap_q
   // in the same cycle the last address of a pass is issued.
   always_comb begin
      lap_off = POS_DIGIT'(32'(wr_lap_q) * LAP_LEN);
      wr_blk  = i_rom_data;
      wr_blk[LEFT_LSB +: POS_DIGIT]  = i_rom_data[LEFT_LSB +: POS_DIGIT] + lap_off;
      wr_blk[RIGHT_LSB +: POS_DIGIT] = i_rom_data[RIGHT_LSB +: POS_DIGIT] + lap_off;
   end

   // ---------------------------------------------------------------- FSM
   always_ff @(posedge i_clk_pix or posedge i_rst) begin
      if (i_rst) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:    if (i_start) state_d = StPreload;
         StPreload: if (!pend_q && !fetch_ok) state_d = StRun;
         StRun:     state_d = StRun;
         default:   state_d = StIdle;
      endcase
   end

   always_comb begin
      o_ready  = (state_q == StRun);
      o_rom_en = (state_q == StPreload || state_q == StRun) && fetch_ok;
   end

   // ---------------------------------------------------------------- datapath
   always_comb begin
      rom_addr_d = rom_addr_q;
      lap_d      = lap_q;
      wr_lap_d   = wr_lap_q;
      pend_d     = pend_q;
      head_d     = head_q;
      tail_d     = tail_q;
      buf_d      = buf_q;
      if (fetch) begin
         pend_d   = 1'b1;
         wr_lap_d = lap_q;
         if (rom_addr_q == STG_ADDRW'(STG_DEPTH - 1)) begin
            rom_addr_d = '0;
            lap_d      = lap_q + 8'd1;
         end else begin
            rom_addr_d = rom_addr_q + STG_ADDRW'(1);
         end
      end
      if (wr) begin
         pend_d         = 1'b0;
         buf_d[tail_q]  = wr_blk;
         tail_d         = tail_q + BUF_AW'(1);
      end
      if (retire) begin
         head_d = head_q + BUF_AW'(1);
      end
      count_d = count_q + (BUF_AW + 1)'(wr) - (BUF_AW + 1)'(retire);
   end

   always_ff @(posedge i_clk_pix or posedge i_rst) begin
      if (i_rst) begin
         rom_addr_q <= '0;
         lap_q      <= '0;
         wr_lap_q   <= '0;
         count_q    <= '0;
         head_q     <= '0;
         tail_q     <= '0;
         pend_q     <= 1'b0;
      end else begin
         rom_addr_q <= rom_addr_d;
         lap_q      <= lap_d;
         wr_lap_q   <= wr_lap_d;
         count_q    <= count_d;
         head_q     <= head_d;
         tail_q     <= tail_d;
         pend_q     <= pend_d;
      end
   end

   // Slot contents are qualified by count_q, so they need no reset.
   always_ff @(posedge i_clk_pix) begin
      buf_q <= buf_d;
   end

   // ---------------------------------------------------------------- read port
   always_comb begin
      rd_ptr     = head_q + i_rd_idx;
      o_rd_blk   = ({1'b0, i_rd_idx} < count_q) ? buf_q[rd_ptr] : '0;
      o_rom_addr = rom_addr_q;
      o_count    = count_q;
      o_lap      = lap_q;
   end

endmodule

// File: tb/tb_stg_scheduler.sv
// Scoreboarded bench for stg_scheduler: expected ROM fetches are queued and matched by a
// monitor; buffer contents and status are checked at directed points.
module tb_stg_scheduler;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [15:0] map_x;
   logic        rom_en;
   logic [2:0]  rom_addr;
   logic [51:0] rom_data;
   logic [2:0]  rd_idx;
   logic [51:0] rd_blk;
   logic [3:0]  count;
   logic        ready;
   logic [7:0]  lap;

   stg_scheduler dut (
      .i_clk_pix  (clk),
      .i_rst      (rst),
      .i_start    (start),
      .i_map_x    (map_x),
      .o_rom_en   (rom_en),
      .o_rom_addr (rom_addr),
      .i_rom_data (rom_data),
      .i_rd_idx   (rd_idx),
      .o_rd_blk   (rd_blk),
      .o_count    (count),
      .o_ready    (ready),
      .o_lap      (lap)
   );

   always #5 clk = ~clk;

   logic [51:0] rom_mem [8];
   always @(posedge clk) begin
      if (rom_en) rom_data <= rom_mem[rom_addr];
   end

   int cyc = 0;
   initial forever begin
      @(posedge clk);
      cyc = cyc + 1;
   end

   int checks = 0;
   int errors = 0;

   typedef struct {
      int c;
      int a;
   } fetch_t;
   fetch_t exp_q[$];

   function automatic logic [51:0] mk(input int l, input int r, input int h, input int s);
      logic [15:0] lf, rf, hf;
      logic [3:0]  sf;
      lf = 16'(l);
      rf = 16'(r);
      hf = 16'(h);
      sf = 4'(s);
      return {lf, rf, hf, sf};
   endfunction

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks = checks + 1;
      if (act !== exp) begin
         errors = errors + 1;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   task automatic push_fetch(input int c, input int a);
      fetch_t e;
      e.c = c;
      e.a = a;
      exp_q.push_back(e);
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic rdb(input int idx, output logic [51:0] v);
      rd_idx = 3'(idx);
      #1;
      v = rd_blk;
   endtask

   task automatic wait_ready(output int at);
      at = -1;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (ready) begin
            at = cyc;
            break;
         end
      end
   endtask

   // Monitor: every ROM strobe must match the next queued fetch in cycle and address.
   initial begin
      fetch_t e;
      forever begin
         @(negedge clk);
         if (!rst && rom_en) begin
            checks = checks + 1;
            if (exp_q.size() == 0) begin
               errors = errors + 1;
               $display("FAIL unexpected_fetch: o_rom_en at cycle %0d addr %0d, none expected",
                        cyc, rom_addr);
            end else begin
               e = exp_q.pop_front();
               if (e.c != cyc || e.a != int'(rom_addr)) begin
                  errors = errors + 1;
                  $display("FAIL fetch: got cycle %0d addr %0d, expected cycle %0d addr %0d",
                           cyc, rom_addr, e.c, e.a);
               end
            end
         end
      end
   end

   initial begin
      int n, m, at;
      logic [51:0] v;
      rst   = 1'b1;
      start = 1'b0;
      map_x = '0;
      rd_idx = '0;
      for (int k = 0; k < 8; k++) rom_mem[k] = mk(k * 100, k * 100 + 80, 16'h100 + k, k);
      repeat (3) next_cycle();
      rst = 1'b0;
      next_cycle();
      @(negedge clk);
      chk("reset_ready", 64'(ready), 64'd0);
      chk("reset_count", 64'(count), 64'd0);
      chk("reset_rom_en", 64'(rom_en), 64'd0);
      chk("reset_addr", 64'(rom_addr), 64'd0);
      chk("reset_lap", 64'(lap), 64'd0);

      // Full preload: fetches on every other cycle until the buffer is full
      next_cycle();
      n = cyc;
      start = 1'b1;
      for (int k = 0; k < 8; k++) push_fetch(n + 1 + 2 * k, k);
      next_cycle();
      start = 1'b0;
      wait_ready(at);
      chk("preload8_ready_cycle", 64'(at), 64'(n + 18));
      chk("preload8_count", 64'(count), 64'd8);
      rdb(0, v);
      chk("preload8_blk0", 64'(v), 64'(mk(0, 80, 16'h100, 0)));
      rdb(7, v);
      chk("preload8_blk7", 64'(v), 64'(mk(700, 780, 16'h107, 7)));
      chk("preload8_lap", 64'(lap), 64'd1);
      chk("preload8_addr", 64'(rom_addr), 64'd0);

      // Start pulse while running changes nothing
      next_cycle();
      start = 1'b1;
      next_cycle();
      start = 1'b0;
      @(negedge clk);
      chk("run_start_ready", 64'(ready), 64'd1);
      chk("run_start_count", 64'(count), 64'd8);
      rdb(0, v);
      chk("run_start_blk0", 64'(v), 64'(mk(0, 80, 16'h100, 0)));
      chk("run_start_addr", 64'(rom_addr), 64'd0);

      // Retire of block 0 followed by a lap-adjusted refill from address 0
      next_cycle();
      m = cyc;
      map_x = 16'd81;
      push_fetch(m + 1, 0);
      @(negedge clk);
      chk("retire_before_edge_count", 64'(count), 64'd8);
      next_cycle();
      @(negedge clk);
      chk("retire_count", 64'(count), 64'd7);
      rdb(0, v);
      chk("retire_blk0", 64'(v), 64'(mk(100, 180, 16'h101, 1)));
      rdb(7, v);
      chk("rd_past_count_zero", 64'(v), 64'd0);
      // Retire coincident with the refill write
      next_cycle();
      map_x = 16'd181;
      next_cycle();
      @(negedge clk);
      chk("coinc_count", 64'(count), 64'd7);
      rdb(0, v);
      chk("coinc_blk0", 64'(v), 64'(mk(200, 280, 16'h102, 2)));
      rdb(6, v);
      chk("refill_lap_adjusted", 64'(v), 64'(mk(4096, 4176, 16'h100, 0)));
      chk("refill_lap", 64'(lap), 64'd1);
      chk("refill_addr", 64'(rom_addr), 64'd1);

      // Reset in the data cycle of an outstanding read
      rst = 1'b1;
      map_x = '0;
      repeat (2) next_cycle();
      rst = 1'b0;
      next_cycle();
      n = cyc;
      start = 1'b1;
      push_fetch(n + 1, 0);
      next_cycle();
      start = 1'b0;
      next_cycle();
      chk("pre_rst_addr", 64'(rom_addr), 64'd1);
      rst = 1'b1;
      #1;
      chk("async_rst_rom_en", 64'(rom_en), 64'd0);
      chk("async_rst_addr", 64'(rom_addr), 64'd0);
      chk("async_rst_lap", 64'(lap), 64'd0);
      chk("async_rst_count", 64'(count), 64'd0);
      chk("async_rst_ready", 64'(ready), 64'd0);
      next_cycle();
      rst = 1'b0;
      repeat (10) next_cycle();
      chk("post_rst_count", 64'(count), 64'd0);
      chk("post_rst_ready", 64'(ready), 64'd0);
      rdb(0, v);
      chk("post_rst_blk0", 64'(v), 64'd0);

      // Lookahead stops preload once the newest left is beyond the visible window
      for (int k = 0; k < 8; k++) rom_mem[k] = mk(k * 500, k * 500 + 80, 16'h200 + k, k);
      next_cycle();
      n = cyc;
      start = 1'b1;
      for (int k = 0; k < 3; k++) push_fetch(n + 1 + 2 * k, k);
      next_cycle();
      start = 1'b0;
      wait_ready(at);
      chk("lookahead_ready_cycle", 64'(at), 64'(n + 8));
      chk("lookahead_count", 64'(count), 64'd3);
      rdb(2, v);
      chk("lookahead_blk2", 64'(v), 64'(mk(1000, 1080, 16'h202, 2)));
      rdb(3, v);
      chk("lookahead_blk3_zero", 64'(v), 64'd0);
      chk("lookahead_addr", 64'(rom_addr), 64'd3);
      chk("lookahead_lap", 64'(lap), 64'd0);
      repeat (5) next_cycle();
      chk("fetch_queue_drained", 64'(exp_q.size()), 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
